sobel_window_gen: RTL
=====================

Name: sobel_window_gen

Overview:
Builds the 3x3 pixel neighbourhood that sobel_kernel consumes, from a raster-order grayscale pixel stream.
- Producer end of the window_valid/window_flat interface.
- Holds two previous image rows in line buffers plus a 3x3 shift-register window.
- Emits one window per accepted pixel once the window lies fully inside the frame. No border padding.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale pixel
IMG_WIDTH, 640, pixels per row (>= 3)
IMG_HEIGHT, 480, rows per frame (>= 3)
COL_W, $clog2(IMG_WIDTH), column counter width
ROW_W, $clog2(IMG_HEIGHT), row counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset (see Behaviour)
pix_valid  in  1  pix_data accepted this cycle; no backpressure
pix_data  in  PIXEL_WIDTH  grayscale pixel, raster order
pix_sof  in  1  start of frame; qualifies the pixel (if any) as row 0, col 0
window_valid  out  1  window_flat/window_row/window_col valid, single-cycle strobe
window_flat  out  PIXEL_WIDTH*9  p0 at [PIXEL_WIDTH-1:0] ... p8 at top; row-major, p0 = top-left, p2 = top-right, p6 = bottom-left, p8 = bottom-right
window_row  out  ROW_W  row of window centre pixel (p4)
window_col  out  COL_W  column of window centre pixel (p4)

Behaviour:
Reset and clocking (already decided):
- One clock, clk; reset rst_n is synchronous, active-low.
- Under reset: window_valid=0, window_flat=0, window_row=0, window_col=0, col/row counters=0, pipeline valids=0.
- Line-buffer and shift-register contents are not reset. Stale data is never emitted because emission is gated by the counters.

Counters and window formation:
- On each accepted pixel (pix_valid=1), col increments. At col==IMG_WIDTH-1 it wraps to 0 and row increments. At row==IMG_HEIGHT-1 with col==IMG_WIDTH-1, both wrap to 0, so the next frame starts without needing sof.
- pix_sof=1 with pix_valid=1: counters forced to row 0, col 0 for that pixel; the previous frame is abandoned.
- pix_sof=1 with pix_valid=0: counters cleared; no window is produced.
- Line buffers: lb0 holds row r-1 and lb1 holds row r-2, each IMG_WIDTH deep and addressed by col. On an accepted pixel: read lb0[col] and lb1[col], write lb0[col]<=pix_data and lb1[col]<=old lb0[col] (read-before-write).
- Window shift: each accepted pixel shifts the new column {lb1 out, lb0 out, pix} into the right side of the 3x3 window. The old left column is dropped.

Emission:
- A window is emitted for a pixel at (r,c) iff r>=2 and c>=2.
- The emitted centre is (r-1, c-1) and p8 is that pixel.
- Per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows.
- Latency: window_valid is asserted exactly 2 clk after the accepting cycle (1 cycle synchronous RAM read, 1 cycle output register).
- Pixel gaps (pix_valid=0) stall the pipeline tags only; output timing is preserved relative to each accepted pixel.
- Back-to-back accepted pixels give back-to-back windows; there is no throughput loss.

Reset mid-frame:
- Any window in flight is discarded; window_valid stays 0.
- The next accepted pixel is treated as row 0, col 0.

Arithmetic:
- Counters use compare-and-wrap, never modulo.
- No arithmetic on pixel data; values are passed through bit-exact.

Decomposition:
- Shared package sobel_pkg holds:
  - PIXEL_WIDTH default
  - window index constants (W_TL=0 ... W_BR=8)
  - a pack/unpack function for window_flat, so sobel_kernel and this block share one layout definition
- One sub-module: sobel_linebuf_ram, a single-port, read-before-write, registered-read RAM (width PIXEL_WIDTH, depth IMG_WIDTH), instantiated twice (or once at 2*PIXEL_WIDTH width).

Test Plan:
1. Basic ramp, IMG_WIDTH=8, IMG_HEIGHT=6, pixel=(row<<4)|col, continuous valid, sof on first pixel -> exactly 24 windows. First window: row=1, col=1, p0..p8 = 00,01,02,10,11,12,20,21,22. It appears 2 cycles after pixel (2,2), which is the 19th pixel. Last window: centre (4,6), p8=0x57.
2. Same ramp with random 30% pix_valid gaps -> identical window sequence and values to test 1; each window exactly 2 cycles after its p8 pixel.
3. Two frames back-to-back without second sof -> frame 2 windows identical to frame 1; no window during rows 0-1 of frame 2 (no stale mixing).
4. pix_sof asserted at frame-1 pixel (3,5) -> no window is formed from that pixel. The next window is centre (1,1) of the new frame, 2 cycles after the new (2,2) pixel.
5. rst_n low for 1 cycle at frame pixel (3,4) with window in flight -> window_valid=0 for the 2 following cycles, all outputs 0. The following sof-less stream restarts at (0,0), and the first window follows the 19th post-reset pixel.
6. Connect sobel_kernel downstream with vertical edge (cols 0-3 = 0x00, cols 4-7 = 0xFF) -> gx=0x3FC (1020) at centre cols 3 and 4, gx=0 elsewhere, gy=0 everywhere.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared window layout for sobel_window_gen and sobel_kernel.
// Tap indices, default pixel width and window pack/unpack helpers.
package sobel_pkg;

    localparam int PIXEL_WIDTH_DEF = 8;
    localparam int WIN_TAPS        = 9;

    // Row-major taps: TL TC TR / ML MC MR / BL BC BR
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    typedef logic [PIXEL_WIDTH_DEF-1:0] pix_t;
    typedef pix_t [WIN_TAPS-1:0]        win_t;

    // Lowest bit of tap idx inside window_flat.
    function automatic int unsigned win_lsb(
        input int unsigned idx,
        input int unsigned pw
    );
        return idx * pw;
    endfunction

    function automatic logic [WIN_TAPS*PIXEL_WIDTH_DEF-1:0] win_pack(
        input win_t w
    );
        logic [WIN_TAPS*PIXEL_WIDTH_DEF-1:0] f;
        f = '0;
        for (int k = 0; k < WIN_TAPS; k++)
            f[k*PIXEL_WIDTH_DEF +: PIXEL_WIDTH_DEF] = w[k];
        return f;
    endfunction

    function automatic win_t win_unpack(
        input logic [WIN_TAPS*PIXEL_WIDTH_DEF-1:0] f
    );
        win_t w;
        for (int k = 0; k < WIN_TAPS; k++)
            w[k] = f[k*PIXEL_WIDTH_DEF +: PIXEL_WIDTH_DEF];
        return w;
    endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// 3x3 window bus between sobel_window_gen (master) and sobel_kernel (slave).
// window_valid strobe, window_flat (p0 at LSB), centre row/col tags.
interface sobel_window_gen_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ROW_W       = 9,
    parameter int COL_W       = 10
);

    logic                     window_valid;
    logic [9*PIXEL_WIDTH-1:0] window_flat;
    logic [ROW_W-1:0]         window_row;
    logic [COL_W-1:0]         window_col;

    modport master (
        output window_valid,
        output window_flat,
        output window_row,
        output window_col
    );

    modport slave (
        input window_valid,
        input window_flat,
        input window_row,
        input window_col
    );

endinterface

// File: rtl/sobel_linebuf_ram.sv
// Single-port line buffer RAM, read-before-write, registered read.
// Ports: clk, en (access), we (write), addr, din, dout (old word, next cycle).
module sobel_linebuf_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= mem[addr];
            if (we)
                mem[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream -> 3x3 windows with centre row/col, 2-cycle latency.
// Ports: clk, rst_n (sync), pix_valid/pix_data/pix_sof in, win (master) out.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int COL_W       = $clog2(IMG_WIDTH),
    parameter int ROW_W       = $clog2(IMG_HEIGHT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_valid,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic                   pix_sof,
    sobel_window_gen_if.master     win
);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             acc;
    logic             emit;

    assign acc     = pix_valid && rst_n;
    assign cur_col = pix_sof ? '0 : col_q;
    assign cur_row = pix_sof ? '0 : row_q;
    assign emit    = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    // Two RAMs selected by row parity: the RAM owned by the current
    // row still holds row r-2 (read before overwrite), the other one
    // holds row r-1. Equivalent to lb0/lb1 without moving data.
    logic [PIXEL_WIDTH-1:0] even_q;
    logic [PIXEL_WIDTH-1:0] odd_q;

    sobel_linebuf_ram #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_lb_even (
        .clk  (clk),
        .en   (acc),
        .we   (acc && !cur_row[0]),
        .addr (cur_col),
        .din  (pix_data),
        .dout (even_q)
    );

    sobel_linebuf_ram #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (COL_W)
    ) u_lb_odd (
        .clk  (clk),
        .en   (acc),
        .we   (acc && cur_row[0]),
        .addr (cur_col),
        .din  (pix_data),
        .dout (odd_q)
    );

    // Stage 1 tags, aligned with the registered RAM read.
    logic                   s1_valid;
    logic                   s1_emit;
    logic                   s1_odd;
    logic [ROW_W-1:0]       s1_row;
    logic [COL_W-1:0]       s1_col;
    logic [PIXEL_WIDTH-1:0] s1_pix;

    logic [PIXEL_WIDTH-1:0] lb_prev;
    logic [PIXEL_WIDTH-1:0] lb_old;

    assign lb_prev = s1_odd ? even_q : odd_q;
    assign lb_old  = s1_odd ? odd_q  : even_q;

    logic [PIXEL_WIDTH-1:0]   win_q    [WIN_TAPS];
    logic [PIXEL_WIDTH-1:0]   win_next [WIN_TAPS];
    logic [9*PIXEL_WIDTH-1:0] flat_next;

    always_comb begin
        win_next[W_TL] = win_q[W_TC];
        win_next[W_TC] = win_q[W_TR];
        win_next[W_TR] = lb_old;
        win_next[W_ML] = win_q[W_MC];
        win_next[W_MC] = win_q[W_MR];
        win_next[W_MR] = lb_prev;
        win_next[W_BL] = win_q[W_BC];
        win_next[W_BC] = win_q[W_BR];
        win_next[W_BR] = s1_pix;
    end

    for (genvar k = 0; k < WIN_TAPS; k++) begin : g_pack
        localparam int LSB = int'(win_lsb(k, PIXEL_WIDTH));
        assign flat_next[LSB +: PIXEL_WIDTH] = win_next[k];
    end

    // Datapath registers: contents never reset, gated by valids.
    always_ff @(posedge clk) begin
        if (acc) begin
            s1_emit <= emit;
            s1_odd  <= cur_row[0];
            s1_row  <= cur_row - ROW_W'(1);
            s1_col  <= cur_col - COL_W'(1);
            s1_pix  <= pix_data;
        end
        if (s1_valid)
            win_q <= win_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q            <= '0;
            row_q            <= '0;
            s1_valid         <= 1'b0;
            win.window_valid <= 1'b0;
            win.window_flat  <= '0;
            win.window_row   <= '0;
            win.window_col   <= '0;
        end else begin
            if (pix_valid) begin
                if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                    col_q <= '0;
                    if (cur_row == ROW_W'(IMG_HEIGHT - 1))
                        row_q <= '0;
                    else
                        row_q <= cur_row + ROW_W'(1);
                end else begin
                    col_q <= cur_col + COL_W'(1);
                    row_q <= cur_row;
                end
            end else if (pix_sof) begin
                col_q <= '0;
                row_q <= '0;
            end
            s1_valid         <= pix_valid;
            win.window_valid <= s1_valid && s1_emit;
            if (s1_valid && s1_emit) begin
                win.window_flat <= flat_next;
                win.window_row  <= s1_row;
                win.window_col  <= s1_col;
            end
        end
    end

endmodule
